xif_copro_wb_arbiter: RTL and testbench

XIF_COPRO_WB_ARBITER -- requirements
Module: xif_copro_wb_arbiter

---
 rtl/xif_copro_pkg.sv | 19 +
 rtl/xif_copro_wb_arbiter_if.sv | 54 +++++
 rtl/xif_copro_result_fifo.sv | 71 +++++++
 rtl/xif_copro_wb_arbiter.sv | 95 +++++++++
 tb/tb_xif_copro_wb_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/xif_copro_pkg.sv
// Shared types and defaults for the coprocessor writeback path.
// Holds the result FIFO entry layout plus default id width and FIFO depth.
// Imported by the arbiter, its interface and the bench.
package xif_copro_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned RES_DEPTH  = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  // One queued XIF result: we = GPR writeback requested on the core side.
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [DATA_W-1:0]     data;
  } result_entry_t;

endpackage

// File: rtl/xif_copro_wb_arbiter_if.sv
// Bundle of all EX, memory, register-file and XIF result signals of the arbiter.
// Ports: ex_* (valid/ready + payload), mem_* (valid + payload, never stalled),
// copreg_* (RF write port), xif_result_* (valid/ready + payload), fifo_count_o, overflow_o.
interface xif_copro_wb_arbiter_if #(
  parameter int unsigned X_ID_WIDTH = xif_copro_pkg::X_ID_WIDTH,
  parameter int unsigned RES_DEPTH  = xif_copro_pkg::RES_DEPTH
);
  logic                    ex_valid_i;
  logic                    ex_ready_o;
  logic [X_ID_WIDTH-1:0]   ex_id_i;
  logic [4:0]              ex_rd_i;
  logic                    ex_rd_is_copro_i;
  logic [31:0]             ex_data_i;

  logic                    mem_valid_i;
  logic [X_ID_WIDTH-1:0]   mem_id_i;
  logic [4:0]              mem_rd_i;
  logic                    mem_we_i;
  logic [31:0]             mem_data_i;

  logic                    copreg_we_o;
  logic [4:0]              copreg_waddr_o;
  logic [31:0]             copreg_wdata_o;

  logic                    xif_result_valid_o;
  logic                    xif_result_ready_i;
  logic [X_ID_WIDTH-1:0]   xif_result_id_o;
  logic [4:0]              xif_result_rd_o;
  logic                    xif_result_we_o;
  logic [31:0]             xif_result_data_o;

  logic [$clog2(RES_DEPTH):0] fifo_count_o;
  logic                       overflow_o;

  // Arbiter side.
  modport slave (
    input  ex_valid_i, ex_id_i, ex_rd_i, ex_rd_is_copro_i, ex_data_i,
    input  mem_valid_i, mem_id_i, mem_rd_i, mem_we_i, mem_data_i,
    input  xif_result_ready_i,
    output ex_ready_o, copreg_we_o, copreg_waddr_o, copreg_wdata_o,
    output xif_result_valid_o, xif_result_id_o, xif_result_rd_o,
    output xif_result_we_o, xif_result_data_o, fifo_count_o, overflow_o
  );

  // Producer / consumer side.
  modport master (
    output ex_valid_i, ex_id_i, ex_rd_i, ex_rd_is_copro_i, ex_data_i,
    output mem_valid_i, mem_id_i, mem_rd_i, mem_we_i, mem_data_i,
    output xif_result_ready_i,
    input  ex_ready_o, copreg_we_o, copreg_waddr_o, copreg_wdata_o,
    input  xif_result_valid_o, xif_result_id_o, xif_result_rd_o,
    input  xif_result_we_o, xif_result_data_o, fifo_count_o, overflow_o
  );
endinterface

// File: rtl/xif_copro_result_fifo.sv
// Result FIFO: circular buffer with wrapping pointers and occupancy count.
// Ports: push_i/push_data_i, pop_i/pop_data_o (head, valid when !empty_o), full_o, empty_o, count_o.
// Latency: push visible at head one cycle later, no bypass; push while full only lands with a pop.
module xif_copro_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = wptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xif_copro_wb_arbiter.sv
// Arbitrates EX and memory results onto the coprocessor RF write port and queues XIF results.
// Ports: clk_i, rst_ni, bus (slave modport: ex/mem inputs, copreg write, xif result, count, overflow).
// Latency: RF write same cycle as accept, XIF result 1 cycle later; memory always wins, EX stalls on full.
module xif_copro_wb_arbiter #(
  parameter int unsigned RES_DEPTH  = xif_copro_pkg::RES_DEPTH,
  parameter int unsigned X_ID_WIDTH = xif_copro_pkg::X_ID_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  xif_copro_wb_arbiter_if.slave  bus
);
  import xif_copro_pkg::*;

  localparam int unsigned CW = $clog2(RES_DEPTH) + 1;

  // Same layout as result_entry_t, but sized by this instance's id width.
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t        push_entry, head_entry;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          ex_ready, ex_acc;
  logic          overflow_q, overflow_d;

  assign fifo_pop = ~fifo_empty & bus.xif_result_ready_i;
  assign ex_ready = ~bus.mem_valid_i & (~fifo_full | fifo_pop);
  assign ex_acc   = bus.ex_valid_i & ex_ready;

  always_comb begin
    push_entry          = '0;
    fifo_push           = 1'b0;
    overflow_d          = overflow_q;
    bus.copreg_we_o     = 1'b0;
    bus.copreg_waddr_o  = '0;
    bus.copreg_wdata_o  = '0;
    if (bus.mem_valid_i) begin
      // Memory results cannot be stalled: the RF write always happens and a
      // full FIFO without a pop drops the result and flags it.
      bus.copreg_we_o    = bus.mem_we_i;
      bus.copreg_waddr_o = bus.mem_rd_i;
      bus.copreg_wdata_o = bus.mem_data_i;
      push_entry.id      = bus.mem_id_i;
      push_entry.rd      = bus.mem_rd_i;
      fifo_push          = ~fifo_full | fifo_pop;
      overflow_d         = overflow_q | (fifo_full & ~fifo_pop);
    end else if (ex_acc) begin
      bus.copreg_we_o    = bus.ex_rd_is_copro_i;
      bus.copreg_waddr_o = bus.ex_rd_i;
      bus.copreg_wdata_o = bus.ex_data_i;
      push_entry.id      = bus.ex_id_i;
      push_entry.rd      = bus.ex_rd_i;
      push_entry.we      = ~bus.ex_rd_is_copro_i;
      push_entry.data    = bus.ex_data_i;
      fifo_push          = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  xif_copro_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.ex_ready_o         = ex_ready;
  assign bus.xif_result_valid_o = ~fifo_empty;
  assign bus.xif_result_id_o    = head_entry.id;
  assign bus.xif_result_rd_o    = head_entry.rd;
  assign bus.xif_result_we_o    = head_entry.we;
  assign bus.xif_result_data_o  = head_entry.data;
  assign bus.fifo_count_o       = fifo_count;
  assign bus.overflow_o         = overflow_q;

endmodule

// File: tb/tb_xif_copro_wb_arbiter.sv
// Directed bench for xif_copro_wb_arbiter: reset, arbitration, full/overflow, ordering, mid-run reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later, away from the edge.
module tb_xif_copro_wb_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  xif_copro_wb_arbiter_if #(.X_ID_WIDTH(4), .RES_DEPTH(4)) bus ();

  xif_copro_wb_arbiter #(.RES_DEPTH(4), .X_ID_WIDTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid_i = 0; bus.ex_id_i = 0; bus.ex_rd_i = 0; bus.ex_rd_is_copro_i = 0; bus.ex_data_i = 0;
    bus.mem_valid_i = 0; bus.mem_id_i = 0; bus.mem_rd_i = 0; bus.mem_we_i = 0; bus.mem_data_i = 0;
  endtask

  task automatic drive_ex(input logic [3:0] id, input logic [4:0] rd, input logic copro, input logic [31:0] data);
    bus.ex_valid_i = 1; bus.ex_id_i = id; bus.ex_rd_i = rd; bus.ex_rd_is_copro_i = copro; bus.ex_data_i = data;
  endtask

  task automatic drive_mem(input logic [3:0] id, input logic [4:0] rd, input logic we, input logic [31:0] data);
    bus.mem_valid_i = 1; bus.mem_id_i = id; bus.mem_rd_i = rd; bus.mem_we_i = we; bus.mem_data_i = data;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle_inputs(); bus.xif_result_ready_i = 0;
    tick(); tick();
    n_cmp++; if (bus.xif_result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.xif_result_valid_o); end
    n_cmp++; if (bus.fifo_count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
    n_cmp++; if (bus.copreg_we_o !== 1'b0) begin n_err++; $display("FAIL reset_copreg_we: got %b want 0", bus.copreg_we_o); end
    n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ex_ready: got %b want 1", bus.ex_ready_o); end
    // A memory result during reset still writes the register file.
    drive_mem(4'd0, 5'd1, 1'b1, 32'h5); settle();
    n_cmp++; if (bus.copreg_we_o !== 1'b1) begin n_err++; $display("FAIL reset_mem_we: got %b want 1", bus.copreg_we_o); end
    tick(); idle_inputs(); settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd0) begin n_err++; $display("FAIL reset_no_push: got %0d want 0", bus.fifo_count_o); end
    rst_ni = 1;
  endtask

  // Runs in the first cycle after reset release.
  task automatic test_ex_basic();
    drive_ex(4'd3, 5'd5, 1'b1, 32'hA5A5A5A5); settle();
    n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_err++; $display("FAIL ex_ready: got %b want 1", bus.ex_ready_o); end
    n_cmp++; if ({bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
      n_err++; $display("FAIL ex_rf_write: got we=%b addr=%0d data=%h want we=1 addr=5 data=a5a5a5a5", bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o); end
    n_cmp++; if (bus.xif_result_valid_o !== 1'b0) begin n_err++; $display("FAIL ex_no_bypass: got %b want 0", bus.xif_result_valid_o); end
    tick(); idle_inputs(); settle();
    n_cmp++; if ({bus.xif_result_valid_o, bus.xif_result_id_o, bus.xif_result_rd_o, bus.xif_result_we_o, bus.xif_result_data_o} !== {1'b1, 4'd3, 5'd5, 1'b0, 32'hA5A5A5A5}) begin
      n_err++; $display("FAIL ex_result: got v=%b id=%0d rd=%0d we=%b data=%h want v=1 id=3 rd=5 we=0 data=a5a5a5a5",
                        bus.xif_result_valid_o, bus.xif_result_id_o, bus.xif_result_rd_o, bus.xif_result_we_o, bus.xif_result_data_o); end
    n_cmp++; if (bus.fifo_count_o !== 3'd1) begin n_err++; $display("FAIL ex_count: got %0d want 1", bus.fifo_count_o); end
    bus.xif_result_ready_i = 1; tick(); bus.xif_result_ready_i = 0; settle();
    n_cmp++; if (bus.xif_result_valid_o !== 1'b0) begin n_err++; $display("FAIL ex_popped: got %b want 0", bus.xif_result_valid_o); end
  endtask

  task automatic test_mem_vs_ex();
    drive_mem(4'd1, 5'd7, 1'b1, 32'h11112222);
    drive_ex(4'd2, 5'd9, 1'b0, 32'h33334444); settle();
    n_cmp++; if (bus.ex_ready_o !== 1'b0) begin n_err++; $display("FAIL arb_ex_stalled: got %b want 0", bus.ex_ready_o); end
    n_cmp++; if ({bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o} !== {1'b1, 5'd7, 32'h11112222}) begin
      n_err++; $display("FAIL arb_mem_write: got we=%b addr=%0d data=%h want we=1 addr=7 data=11112222", bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o); end
    tick(); bus.mem_valid_i = 0; settle();
    n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_err++; $display("FAIL arb_ex_next: got %b want 1", bus.ex_ready_o); end
    n_cmp++; if ({bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o} !== {1'b0, 5'd9, 32'h33334444}) begin
      n_err++; $display("FAIL arb_ex_write: got we=%b addr=%0d data=%h want we=0 addr=9 data=33334444", bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o); end
    n_cmp++; if ({bus.xif_result_id_o, bus.xif_result_we_o, bus.xif_result_data_o} !== {4'd1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL arb_first_mem: got id=%0d we=%b data=%h want id=1 we=0 data=0", bus.xif_result_id_o, bus.xif_result_we_o, bus.xif_result_data_o); end
    tick(); idle_inputs(); settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd2) begin n_err++; $display("FAIL arb_count: got %0d want 2", bus.fifo_count_o); end
    bus.xif_result_ready_i = 1; tick(); settle();
    n_cmp++; if ({bus.xif_result_valid_o, bus.xif_result_id_o, bus.xif_result_we_o, bus.xif_result_data_o} !== {1'b1, 4'd2, 1'b1, 32'h33334444}) begin
      n_err++; $display("FAIL arb_second_ex: got v=%b id=%0d we=%b data=%h want v=1 id=2 we=1 data=33334444",
                        bus.xif_result_valid_o, bus.xif_result_id_o, bus.xif_result_we_o, bus.xif_result_data_o); end
    tick(); bus.xif_result_ready_i = 0; settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd0) begin n_err++; $display("FAIL arb_drained: got %0d want 0", bus.fifo_count_o); end
  endtask

  task automatic test_full();
    bus.xif_result_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      drive_ex(4'(4 + k), 5'(k), 1'b1, 32'(k)); settle();
      n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_err++; $display("FAIL full_fill_ready%0d: got %b want 1", k, bus.ex_ready_o); end
      tick();
    end
    drive_ex(4'd8, 5'd8, 1'b1, 32'h8); settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", bus.fifo_count_o); end
    n_cmp++; if (bus.ex_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ex_ready: got %b want 0", bus.ex_ready_o); end
    tick();
    bus.xif_result_ready_i = 1; settle();
    n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ready: got %b want 1", bus.ex_ready_o); end
    n_cmp++; if (bus.xif_result_id_o !== 4'd4) begin n_err++; $display("FAIL full_head_before: got %0d want 4", bus.xif_result_id_o); end
    tick(); idle_inputs(); bus.xif_result_ready_i = 0; settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 4", bus.fifo_count_o); end
    n_cmp++; if (bus.xif_result_id_o !== 4'd5) begin n_err++; $display("FAIL full_head_after: got %0d want 5", bus.xif_result_id_o); end
  endtask

  // Continues from a full FIFO holding ids 5,6,7,8.
  task automatic test_overflow();
    drive_mem(4'd9, 5'd3, 1'b1, 32'hDEADBEEF); settle();
    n_cmp++; if ({bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL ovf_rf_write: got we=%b addr=%0d data=%h want we=1 addr=3 data=deadbeef", bus.copreg_we_o, bus.copreg_waddr_o, bus.copreg_wdata_o); end
    tick(); idle_inputs(); settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_o); end
    bus.xif_result_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++; if ({bus.xif_result_valid_o, bus.xif_result_id_o} !== {1'b1, 4'(5 + k)}) begin
        n_err++; $display("FAIL ovf_drain%0d: got v=%b id=%0d want v=1 id=%0d", k, bus.xif_result_valid_o, bus.xif_result_id_o, 5 + k); end
      tick();
    end
    bus.xif_result_ready_i = 0; settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd0) begin n_err++; $display("FAIL ovf_dropped: got %0d want 0", bus.fifo_count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
  endtask

  task automatic test_interleaved();
    int q[$];
    int next_id = 0;
    int popped  = 0;
    int cycles  = 0;
    logic will_push, exp_pop, exp_rdy, drove_ex;
    while (popped < 10 && cycles < 200) begin
      idle_inputs(); will_push = 0; drove_ex = 0;
      if (next_id < 10) begin
        if (next_id % 3 == 1) begin
          if (q.size() < 4) begin drive_mem(4'(next_id), 5'(next_id), 1'b1, 32'(next_id)); will_push = 1; end
        end else begin
          drive_ex(4'(next_id), 5'(next_id), next_id[0], 32'hC0000000 + 32'(next_id)); drove_ex = 1;
        end
      end
      bus.xif_result_ready_i = 1'($urandom_range(0, 1));
      settle();
      exp_pop = (q.size() != 0) && bus.xif_result_ready_i;
      n_cmp++; if (int'(bus.fifo_count_o) !== q.size()) begin n_err++; $display("FAIL mix_count c%0d: got %0d want %0d", cycles, bus.fifo_count_o, q.size()); end
      n_cmp++; if (bus.xif_result_valid_o !== (q.size() != 0)) begin n_err++; $display("FAIL mix_valid c%0d: got %b want %b", cycles, bus.xif_result_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (int'(bus.xif_result_id_o) !== q[0]) begin n_err++; $display("FAIL mix_order c%0d: got id %0d want %0d", cycles, bus.xif_result_id_o, q[0]); end
      end
      if (drove_ex) begin
        exp_rdy = (q.size() < 4) || exp_pop;
        n_cmp++; if (bus.ex_ready_o !== exp_rdy) begin n_err++; $display("FAIL mix_ex_ready c%0d: got %b want %b", cycles, bus.ex_ready_o, exp_rdy); end
        will_push = exp_rdy;
      end
      tick();
      if (exp_pop) begin void'(q.pop_front()); popped++; end
      if (will_push) begin q.push_back(next_id); next_id++; end
      cycles++;
    end
    idle_inputs(); bus.xif_result_ready_i = 0;
    n_cmp++; if (popped != 10) begin n_err++; $display("FAIL mix_timeout: got %0d results want 10", popped); end
  endtask

  task automatic test_reset_mid();
    bus.xif_result_ready_i = 0;
    for (int k = 0; k < 3; k++) begin drive_ex(4'(k + 1), 5'(k), 1'b1, 32'(k)); tick(); end
    idle_inputs(); settle();
    n_cmp++; if (bus.fifo_count_o !== 3'd3) begin n_err++; $display("FAIL rstmid_count: got %0d want 3", bus.fifo_count_o); end
    rst_ni = 0; settle();
    n_cmp++; if (bus.xif_result_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.xif_result_valid_o); end
    n_cmp++; if (bus.fifo_count_o !== 3'd0) begin n_err++; $display("FAIL rstmid_cleared: got %0d want 0", bus.fifo_count_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow: got %b want 0", bus.overflow_o); end
    tick(); tick(); rst_ni = 1; bus.xif_result_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++; if (bus.xif_result_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stale%0d: got %b want 0", k, bus.xif_result_valid_o); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_basic();
    test_mem_vs_ex();
    test_full();
    test_overflow();
    test_interleaved();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
